// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: default bus widths, FSM state and op encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arbiter_pkg;

  localparam int MA_AW = 32;
  localparam int MA_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } op_t;

  // Read wins when a requester raises both strobes; the write is dropped.
  function automatic op_t req_op(input logic rd);
    return rd ? OP_READ : OP_WRITE;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both requester ports, the memory port and arbiter status.
// Latency: n/a (wires only).
// Backpressure: requesters hold read/write until their ready pulse.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int AW = MA_AW,
  parameter int DW = MA_DW
);

  logic          m0_read;
  logic          m0_write;
  logic [AW-1:0] m0_address;
  logic [DW-1:0] m0_dout;
  logic [DW-1:0] m0_din;
  logic          m0_ready;

  logic          m1_read;
  logic          m1_write;
  logic [AW-1:0] m1_address;
  logic [DW-1:0] m1_dout;
  logic [DW-1:0] m1_din;
  logic          m1_ready;

  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          owner;

  // Arbiter side
  modport slave (
    input  m0_read, m0_write, m0_address, m0_dout,
    input  m1_read, m1_write, m1_address, m1_dout,
    input  mem_rdata,
    output m0_din, m0_ready, m1_din, m1_ready,
    output mem_read, mem_write, mem_address, mem_wdata,
    output busy, owner
  );

  // Requesters plus memory side
  modport master (
    output m0_read, m0_write, m0_address, m0_dout,
    output m1_read, m1_write, m1_address, m1_dout,
    output mem_rdata,
    input  m0_din, m0_ready, m1_din, m1_ready,
    input  mem_read, mem_write, mem_address, mem_wdata,
    input  busy, owner
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: grants the sole active requester, or the one that did not win last.
// Latency: combinational.
// Backpressure: none; caller decides when the pick is consumed.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] act,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // On a tie the previous winner yields, so neither side can starve
  always_comb begin
    gnt_valid = |act;
    gnt_id    = 1'b0;
    if (act == 2'b11) begin
      gnt_id = ~last;
    end else if (act[1]) begin
      gnt_id = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto one single-port memory, one access at a time.
// Latency: grant cycle N -> strobe N+1; write ready N+2, read ready N+3 (data in din with ready).
// Backpressure: requests are level-held; while busy they are ignored and re-arbitrated in IDLE.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW = MA_AW,
  parameter int DW = MA_DW
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_last;
  logic          r_id;
  op_t           r_op;

  // Output registers; mem_address/mem_wdata double as the address/data latches
  // since nothing needs them after the single ISSUE cycle.
  logic          r_mem_read,  w_mem_read_nxt;
  logic          r_mem_write, w_mem_write_nxt;
  logic [AW-1:0] r_mem_address, w_mem_address_nxt;
  logic [DW-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic          r_busy,      w_busy_nxt;
  logic          r_m0_ready,  w_m0_ready_nxt;
  logic          r_m1_ready,  w_m1_ready_nxt;
  logic [DW-1:0] r_m0_din,    w_m0_din_nxt;
  logic [DW-1:0] r_m1_din,    w_m1_din_nxt;

  logic [1:0]    w_act;
  logic          w_gnt_valid;
  logic          w_gnt_id;
  logic          w_gnt_read;
  logic [AW-1:0] w_gnt_addr;
  logic [DW-1:0] w_gnt_wdata;
  logic          w_take;

  assign w_act       = {bus.m1_read | bus.m1_write, bus.m0_read | bus.m0_write};
  assign w_gnt_read  = w_gnt_id ? bus.m1_read    : bus.m0_read;
  assign w_gnt_addr  = w_gnt_id ? bus.m1_address : bus.m0_address;
  assign w_gnt_wdata = w_gnt_id ? bus.m1_dout    : bus.m0_dout;
  assign w_take      = (r_state == ST_IDLE) && w_gnt_valid;

  rr_arb2 u_rr_arb2 (
    .act       (w_act),
    .last      (r_last),
    .gnt_valid (w_gnt_valid),
    .gnt_id    (w_gnt_id)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: fixed walk IDLE -> ISSUE -> (WAIT for reads) -> DONE -> IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_state_nxt = w_gnt_valid ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: w_state_nxt = (r_op == OP_READ) ? ST_WAIT : ST_DONE;
      ST_WAIT:  w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Grant bookkeeping: owner id, op and round-robin history; reset makes m0 win the first tie
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last <= 1'b1;
      r_id   <= 1'b0;
      r_op   <= OP_WRITE;
    end else if (w_take) begin
      r_last <= w_gnt_id;
      r_id   <= w_gnt_id;
      r_op   <= req_op(w_gnt_read);
    end
  end

  // Output next-values, chosen one cycle ahead so every output comes straight from a flop
  always_comb begin
    w_mem_read_nxt    = 1'b0;
    w_mem_write_nxt   = 1'b0;
    w_mem_address_nxt = '0;
    w_mem_wdata_nxt   = '0;
    w_m0_ready_nxt    = 1'b0;
    w_m1_ready_nxt    = 1'b0;
    w_m0_din_nxt      = r_m0_din;
    w_m1_din_nxt      = r_m1_din;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_valid) begin
          w_mem_read_nxt    = w_gnt_read;
          w_mem_write_nxt   = ~w_gnt_read;
          w_mem_address_nxt = w_gnt_addr;
          w_mem_wdata_nxt   = w_gnt_wdata;
        end
      end
      ST_ISSUE: begin
        if (r_op == OP_WRITE) begin
          w_m0_ready_nxt = ~r_id;
          w_m1_ready_nxt = r_id;
        end
      end
      ST_WAIT: begin
        w_m0_ready_nxt = ~r_id;
        w_m1_ready_nxt = r_id;
        if (r_id) begin
          w_m1_din_nxt = bus.mem_rdata;
        end else begin
          w_m0_din_nxt = bus.mem_rdata;
        end
      end
      default: begin
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // Output registers; reset clears everything, which also drops any in-flight ready
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
      r_busy        <= 1'b0;
      r_m0_ready    <= 1'b0;
      r_m1_ready    <= 1'b0;
      r_m0_din      <= '0;
      r_m1_din      <= '0;
    end else begin
      r_mem_read    <= w_mem_read_nxt;
      r_mem_write   <= w_mem_write_nxt;
      r_mem_address <= w_mem_address_nxt;
      r_mem_wdata   <= w_mem_wdata_nxt;
      r_busy        <= w_busy_nxt;
      r_m0_ready    <= w_m0_ready_nxt;
      r_m1_ready    <= w_m1_ready_nxt;
      r_m0_din      <= w_m0_din_nxt;
      r_m1_din      <= w_m1_din_nxt;
    end
  end

  assign bus.mem_read    = r_mem_read;
  assign bus.mem_write   = r_mem_write;
  assign bus.mem_address = r_mem_address;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.busy        = r_busy;
  assign bus.owner       = r_id;
  assign bus.m0_ready    = r_m0_ready;
  assign bus.m1_ready    = r_m1_ready;
  assign bus.m0_din      = r_m0_din;
  assign bus.m1_din      = r_m1_din;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed requester scripts, a memory responder and a transaction-level model.
// Latency: model schedules each grant's visible effects on a short cycle timeline.
// Backpressure: requesters hold requests until ready and drop them the following cycle.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   ncyc     = 0;

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", ncyc);
    $fatal(1);
  end

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // ---------------- memory responder: data appears the cycle after mem_read ----------------
  logic [31:0] tmem [256];
  logic        rd_pend;
  logic [31:0] rd_val;

  always @(negedge clk) begin
    if (bus.mem_write) tmem[bus.mem_address[7:0]] = bus.mem_wdata;
    rd_pend = bus.mem_read;
    rd_val  = tmem[bus.mem_address[7:0]];
  end

  always @(posedge clk) begin
    #1;
    bus.mem_rdata = rd_pend ? rd_val : 32'h0;
  end

  // ---------------- transaction model on a 16-slot cycle timeline ----------------
  logic        e_rd [16], e_wr [16], e_busy [16], e_rdy0 [16], e_rdy1 [16];
  logic        e_own_upd [16], e_own_val [16], e_rst [16], e_dupd0 [16], e_dupd1 [16];
  logic [31:0] e_addr [16], e_wdata [16], e_dval0 [16], e_dval1 [16];
  logic [31:0] m_mem [256];
  logic [31:0] m_din0, m_din1;
  logic        m_owner, m_last, m_live;
  int          m_free_at;

  task automatic clr_slot(input logic [3:0] k);
    e_rd[k] = 0; e_wr[k] = 0; e_busy[k] = 0; e_rdy0[k] = 0; e_rdy1[k] = 0;
    e_own_upd[k] = 0; e_own_val[k] = 0; e_rst[k] = 0; e_dupd0[k] = 0; e_dupd1[k] = 0;
    e_addr[k] = 0; e_wdata[k] = 0; e_dval0[k] = 0; e_dval1[k] = 0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) clr_slot(4'(i));
    for (int i = 0; i < 256; i++) begin
      tmem[i]  = 32'hC0DE0000 + 32'(i);
      m_mem[i] = 32'hC0DE0000 + 32'(i);
    end
    m_din0 = 0; m_din1 = 0; m_owner = 0; m_last = 1; m_live = 0; m_free_at = 0;
  end

  always @(negedge clk) begin
    logic [3:0]  s;
    logic        a0, a1, id, rd;
    logic [31:0] ad, wd;
    s = 4'(ncyc);
    if (e_rst[s]) begin m_din0 = 0; m_din1 = 0; m_owner = 0; end
    if (e_dupd0[s]) m_din0 = e_dval0[s];
    if (e_dupd1[s]) m_din1 = e_dval1[s];
    if (e_own_upd[s]) m_owner = e_own_val[s];
    if (m_live) begin
      chk_b("mem_read",    bus.mem_read,    e_rd[s]);
      chk_b("mem_write",   bus.mem_write,   e_wr[s]);
      chk_w("mem_address", bus.mem_address, e_addr[s]);
      chk_w("mem_wdata",   bus.mem_wdata,   e_wdata[s]);
      chk_b("busy",        bus.busy,        e_busy[s]);
      chk_b("owner",       bus.owner,       m_owner);
      chk_b("m0_ready",    bus.m0_ready,    e_rdy0[s]);
      chk_b("m1_ready",    bus.m1_ready,    e_rdy1[s]);
      chk_w("m0_din",      bus.m0_din,      m_din0);
      chk_w("m1_din",      bus.m1_din,      m_din1);
    end
    clr_slot(s);
    if (!rst) begin
      for (int k = 1; k <= 4; k++) clr_slot(s + 4'(k));
      e_rst[s + 4'd1] = 1;
      m_last = 1; m_free_at = ncyc + 1; m_live = 1;
    end else if (m_live && ncyc >= m_free_at) begin
      a0 = bus.m0_read | bus.m0_write;
      a1 = bus.m1_read | bus.m1_write;
      if (a0 || a1) begin
        if (a0 && a1) id = (m_last == 1'b1) ? 1'b0 : 1'b1;
        else          id = a0 ? 1'b0 : 1'b1;
        rd = id ? bus.m1_read    : bus.m0_read;
        ad = id ? bus.m1_address : bus.m0_address;
        wd = id ? bus.m1_dout    : bus.m0_dout;
        e_busy[s + 4'd1] = 1; e_own_upd[s + 4'd1] = 1; e_own_val[s + 4'd1] = id;
        e_rd[s + 4'd1] = rd; e_wr[s + 4'd1] = !rd;
        e_addr[s + 4'd1] = ad; e_wdata[s + 4'd1] = wd;
        e_busy[s + 4'd2] = 1;
        if (rd) begin
          e_busy[s + 4'd3] = 1;
          if (id) begin e_rdy1[s + 4'd3] = 1; e_dupd1[s + 4'd3] = 1; e_dval1[s + 4'd3] = m_mem[ad[7:0]]; end
          else    begin e_rdy0[s + 4'd3] = 1; e_dupd0[s + 4'd3] = 1; e_dval0[s + 4'd3] = m_mem[ad[7:0]]; end
          m_free_at = ncyc + 4;
        end else begin
          if (id) e_rdy1[s + 4'd2] = 1; else e_rdy0[s + 4'd2] = 1;
          m_mem[ad[7:0]] = wd;
          m_free_at = ncyc + 3;
        end
        m_last = id;
      end
    end
    ncyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (id == 0) begin
      bus.m0_read = rd; bus.m0_write = wr; bus.m0_address = a; bus.m0_dout = d;
    end else begin
      bus.m1_read = rd; bus.m1_write = wr; bus.m1_address = a; bus.m1_dout = d;
    end
  endtask

  task automatic do_reset();
    tick(); rst = 1'b0;
    tick(); rst = 1'b1;
  endtask

  // Issue n requests back to back, each held until ready and dropped the cycle after
  task automatic run_req(input int id, input int n, input logic rd, input logic wr,
                         input logic [31:0] a0, input logic [31:0] d0);
    for (int k = 0; k < n; k++) begin
      int w;
      logic got;
      tick();
      drive(id, rd, wr, a0 + 32'(4 * k), d0 + 32'(k));
      got = 0;
      w = 0;
      while (!got && w < 20) begin
        @(negedge clk);
        got = (id == 0) ? bus.m0_ready : bus.m1_ready;
        w++;
      end
      if (!got) chk_b("req_ready_timeout", 1'b0, 1'b1);
      tick();
      drive(id, 0, 0, 0, 0);
    end
  endtask

  logic q_own [$];
  logic exp_own [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk_b("reset_busy", bus.busy, 1'b0);
    chk_w("reset_m0_din", bus.m0_din, 32'h0);

    // m0 write 0x10 <- DEADBEEF
    tick(); drive(0, 0, 1, 32'h10, 32'hDEADBEEF);
    tick(); @(negedge clk);
    chk_b("t1_mem_write", bus.mem_write, 1'b1);
    chk_w("t1_mem_address", bus.mem_address, 32'h10);
    chk_w("t1_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    tick(); @(negedge clk);
    chk_b("t1_m0_ready", bus.m0_ready, 1'b1);
    tick(); drive(0, 0, 0, 0, 0);

    // m1 read 0x10
    tick(); drive(1, 1, 0, 32'h10, 32'h0);
    tick(); @(negedge clk);
    chk_b("t2_mem_read", bus.mem_read, 1'b1);
    tick();
    tick(); @(negedge clk);
    chk_b("t2_m1_ready", bus.m1_ready, 1'b1);
    chk_w("t2_m1_din", bus.m1_din, 32'hDEADBEEF);
    tick(); drive(1, 0, 0, 0, 0);

    // both write from cycle 0 after reset: m0 first, m1 after
    do_reset();
    tick();
    drive(0, 0, 1, 32'h20, 32'h11111111);
    drive(1, 0, 1, 32'h24, 32'h22222222);
    tick(); @(negedge clk);
    chk_b("t3_owner_first", bus.owner, 1'b0);
    tick(); @(negedge clk);
    chk_b("t3_m0_ready_c2", bus.m0_ready, 1'b1);
    tick(); drive(0, 0, 0, 0, 0);
    tick(); @(negedge clk);
    chk_b("t3_owner_second", bus.owner, 1'b1);
    chk_w("t3_wdata_second", bus.mem_wdata, 32'h22222222);
    tick(); @(negedge clk);
    chk_b("t3_m1_ready_c5", bus.m1_ready, 1'b1);
    tick(); drive(1, 0, 0, 0, 0);

    // read+write together on m0 collapses to a read
    tick(); drive(0, 1, 1, 32'h4, 32'hBAD0BAD0);
    tick(); @(negedge clk);
    chk_b("t4_mem_read", bus.mem_read, 1'b1);
    chk_b("t4_mem_write", bus.mem_write, 1'b0);
    tick();
    tick(); @(negedge clk);
    chk_w("t4_m0_din", bus.m0_din, 32'hC0DE0004);
    tick(); drive(0, 0, 0, 0, 0);

    // continuous reads from both: 8 grants alternate starting with m0
    do_reset();
    fork
      run_req(0, 4, 1'b1, 1'b0, 32'h40, 32'h0);
      run_req(1, 4, 1'b1, 1'b0, 32'h80, 32'h0);
    join_none
    for (int w = 0; w < 80 && q_own.size() < 8; w++) begin
      @(negedge clk);
      if (bus.mem_read) q_own.push_back(bus.owner);
    end
    wait fork;
    chk_w("t5_grant_count", 32'(q_own.size()), 32'd8);
    for (int k = 0; k < 8 && k < q_own.size(); k++) chk_b("t5_owner_seq", q_own[k], exp_own[k]);

    // request dropped after grant still completes on latched values
    tick(); drive(0, 0, 1, 32'h30, 32'h12345678);
    tick(); drive(0, 0, 0, 32'h99, 32'hFFFFFFFF);
    @(negedge clk);
    chk_w("t6_mem_address", bus.mem_address, 32'h30);
    chk_w("t6_mem_wdata", bus.mem_wdata, 32'h12345678);
    tick(); @(negedge clk);
    chk_b("t6_m0_ready", bus.m0_ready, 1'b1);
    drive(0, 0, 0, 0, 0);
    run_req(1, 1, 1'b1, 1'b0, 32'h30, 32'h0);
    @(negedge clk);
    chk_w("t6_m1_din_held", bus.m1_din, 32'h12345678);

    // reset during WAIT aborts the read; next tie goes to m0
    tick(); drive(1, 1, 0, 32'h10, 32'h0);
    tick();
    tick(); rst = 1'b0; drive(1, 0, 0, 0, 0);
    tick(); rst = 1'b1;
    @(negedge clk);
    chk_b("t7_busy", bus.busy, 1'b0);
    chk_b("t7_m1_ready", bus.m1_ready, 1'b0);
    chk_w("t7_m1_din", bus.m1_din, 32'h0);
    tick();
    drive(0, 0, 1, 32'h50, 32'h0000000A);
    drive(1, 0, 1, 32'h54, 32'h0000000B);
    tick(); @(negedge clk);
    chk_b("t7_tie_owner", bus.owner, 1'b0);
    chk_w("t7_tie_address", bus.mem_address, 32'h50);
    tick(); @(negedge clk);
    chk_b("t7_m0_ready", bus.m0_ready, 1'b1);
    tick(); drive(0, 0, 0, 0, 0);
    tick();
    tick(); @(negedge clk);
    chk_b("t7_m1_ready", bus.m1_ready, 1'b1);
    tick(); drive(1, 0, 0, 0, 0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
